seq_match_detector: RTL and testbench

Serial pattern detector sitting directly downstream of the parallel-in/serial-out loader. It consumes one qualified bit per cycle and compares the last four accepted bits against a latched 4-bit target pattern, in overlapping or non-overlapping mode. It produces a one-cycle match pulse, saturating 0–99 match and bit counters for the BCD/7-segment path, and an 18-bit history of accepted bits for the red LED bank.

---
 rtl/strrec_pkg.sv | 15 +
 rtl/seq_match_detector_if.sv | 30 +++
 rtl/sat_counter.sv | 34 +++
 rtl/seq_match_detector.sv | 92 +++++++++
 tb/tb_seq_match_detector.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/strrec_pkg.sv
// Shared constants and types for the serial pattern detector and its counters.
package strrec_pkg;
    localparam int DEF_PAT_W   = 4;
    localparam int DEF_CNT_MAX = 99;
    localparam int DEF_HIST_W  = 18;
    localparam int CNT_W       = 7;

    typedef enum logic [2:0] {
        EMPTY = 3'd0,
        F1    = 3'd1,
        F2    = 3'd2,
        F3    = 3'd3,
        FULL  = 3'd4
    } fill_t;
endpackage

// File: rtl/seq_match_detector_if.sv
// Stream, control and status signals of the pattern detector, grouped for port binding.
interface seq_match_detector_if
    import strrec_pkg::*;
#(
    parameter int PAT_W  = DEF_PAT_W,
    parameter int HIST_W = DEF_HIST_W
) ();
    // bit_valid qualifies bit_in for exactly one cycle; there is no ready, every valid bit is taken.
    logic              bit_in;
    logic              bit_valid;
    logic [PAT_W-1:0]  pattern;
    logic              overlap;
    logic              clear;
    logic              match;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [HIST_W-1:0] history;
    logic [PAT_W-1:0]  pat_q;
    fill_t             fill_state;

    modport master (
        output bit_in, bit_valid, pattern, overlap, clear,
        input  match, match_cnt, bit_cnt, history, pat_q, fill_state
    );

    modport slave (
        input  bit_in, bit_valid, pattern, overlap, clear,
        output match, match_cnt, bit_cnt, history, pat_q, fill_state
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that stops at CNT_MAX; synchronous clear, synchronous active-low reset.
module sat_counter
    import strrec_pkg::*;
#(
    parameter int CNT_MAX = DEF_CNT_MAX,
    parameter int W       = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < W'(CNT_MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/seq_match_detector.sv
// Serial 4-bit pattern detector with overlap/non-overlap mode, saturating counters and bit history.
module seq_match_detector
    import strrec_pkg::*;
#(
    parameter int PAT_W   = DEF_PAT_W,
    parameter int CNT_MAX = DEF_CNT_MAX,
    parameter int HIST_W  = DEF_HIST_W
) (
    input logic                 clk,
    input logic                 rst_n,
    seq_match_detector_if.slave bus
);
    fill_t             state_q, state_d;
    logic [PAT_W-1:0]  win_q, win_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic              match_q, match_d;
    logic [PAT_W-1:0]  win_next;
    logic              accept;
    logic              hit;

    always_comb begin
        accept   = bus.bit_valid && !bus.clear;
        win_next = {win_q[PAT_W-2:0], bus.bit_in};
        // Only windows filled with PAT_W bits since the last restart may hit.
        hit      = accept && ((state_q == F3) || (state_q == FULL)) && (win_next == pat_q);

        state_d = state_q;
        win_d   = win_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        match_d = 1'b0;

        if (bus.clear) begin
            state_d = EMPTY;
            win_d   = '0;
            hist_d  = '0;
            pat_d   = bus.pattern;
        end else if (accept) begin
            win_d   = win_next;
            hist_d  = {hist_q[HIST_W-2:0], bus.bit_in};
            match_d = hit;
            if (hit) begin
                state_d = bus.overlap ? FULL : EMPTY;
            end else begin
                case (state_q)
                    EMPTY:   state_d = F1;
                    F1:      state_d = F2;
                    F2:      state_d = F3;
                    default: state_d = FULL;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            win_q   <= '0;
            pat_q   <= bus.pattern;
            hist_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            match_q <= match_d;
        end
    end

    sat_counter #(.CNT_MAX(CNT_MAX), .W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clear),
        .inc   (hit),
        .cnt   (bus.match_cnt)
    );

    sat_counter #(.CNT_MAX(CNT_MAX), .W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clear),
        .inc   (accept),
        .cnt   (bus.bit_cnt)
    );

    assign bus.match      = match_q;
    assign bus.history    = hist_q;
    assign bus.pat_q      = pat_q;
    assign bus.fill_state = state_q;
endmodule

// File: tb/tb_seq_match_detector.sv
// Directed bench for seq_match_detector: streams, bubbles, saturation, clear and reset.
module tb_seq_match_detector;
    import strrec_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_match_detector_if bus ();

    seq_match_detector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    logic exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Holds reset for one edge while a valid bit is offered; reset must win.
    task automatic do_reset(input logic [3:0] pat, input logic ov, input string tag);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.clear     = 1'b0;
        bus.pattern   = pat;
        bus.overlap   = ov;
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_rst_match"}, 32'(bus.match), 32'd0);
        check_eq({tag, "_rst_match_cnt"}, 32'(bus.match_cnt), 32'd0);
        check_eq({tag, "_rst_bit_cnt"}, 32'(bus.bit_cnt), 32'd0);
        check_eq({tag, "_rst_history"}, 32'(bus.history), 32'd0);
        check_eq({tag, "_rst_pat_q"}, 32'(bus.pat_q), 32'(pat));
        check_eq({tag, "_rst_fill"}, 32'(bus.fill_state), 32'(EMPTY));
    endtask

    // Releases reset on the same edge that carries the bit, so the first bit after reset is tested too.
    task automatic send(input logic b, input logic exp_match, input string tag);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.clear     = 1'b0;
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        @(posedge clk);
        #1;
        check_eq(tag, 32'(bus.match), 32'(exp_match));
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst_n         = 1'b1;
            bus.clear     = 1'b0;
            bus.bit_valid = 1'b0;
            bus.bit_in    = 1'b1;
            @(posedge clk);
            #1;
            check_eq($sformatf("%s_idle%0d", tag, k), 32'(bus.match), 32'd0);
        end
    endtask

    // bits[n-1] is sent first; mexp[i] is the match expected right after bits[i].
    task automatic run_stream(input logic [31:0] bits, input logic [31:0] mexp, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(mexp[i]);
        for (int i = n - 1; i >= 0; i--) begin
            if (exp_q.size() == 0) begin
                check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
            end else begin
                send(bits[i], exp_q.pop_front(), $sformatf("%s_match_bit%0d", tag, n - i));
            end
        end
    endtask

    initial begin
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.pattern   = 4'b0000;
        bus.overlap   = 1'b1;
        bus.clear     = 1'b0;

        // Overlap, 1011 over 1011011
        do_reset(4'b1011, 1'b1, "ov1011");
        run_stream(32'b1011011, 32'b0001001, 7, "ov1011");
        check_eq("ov1011_match_cnt", 32'(bus.match_cnt), 32'd2);
        check_eq("ov1011_bit_cnt", 32'(bus.bit_cnt), 32'd7);
        check_eq("ov1011_history", 32'(bus.history[6:0]), 32'b1011011);
        check_eq("ov1011_fill", 32'(bus.fill_state), 32'(FULL));
        idle(2, "ov1011");
        check_eq("ov1011_hold_bit_cnt", 32'(bus.bit_cnt), 32'd7);

        // Non-overlap, same stream
        do_reset(4'b1011, 1'b0, "nov1011");
        run_stream(32'b1011011, 32'b0001000, 7, "nov1011");
        check_eq("nov1011_match_cnt", 32'(bus.match_cnt), 32'd1);
        check_eq("nov1011_fill", 32'(bus.fill_state), 32'(F3));

        // 1111 over seven 1s
        do_reset(4'b1111, 1'b1, "ov1111");
        run_stream(32'b1111111, 32'b0001111, 7, "ov1111");
        check_eq("ov1111_match_cnt", 32'(bus.match_cnt), 32'd4);
        do_reset(4'b1111, 1'b0, "nov1111");
        run_stream(32'b1111111, 32'b0001000, 7, "nov1111");
        check_eq("nov1111_match_cnt", 32'(bus.match_cnt), 32'd1);

        // Bubbles between valid bits
        do_reset(4'b0110, 1'b1, "bub");
        send(1'b0, 1'b0, "bub_b1");
        idle(3, "bub_gap1");
        send(1'b1, 1'b0, "bub_b2");
        idle(3, "bub_gap2");
        send(1'b1, 1'b0, "bub_b3");
        idle(3, "bub_gap3");
        send(1'b0, 1'b1, "bub_b4");
        idle(1, "bub_after");
        check_eq("bub_bit_cnt", 32'(bus.bit_cnt), 32'd4);
        check_eq("bub_match_cnt", 32'(bus.match_cnt), 32'd1);

        // Saturation with 120 ones
        do_reset(4'b1111, 1'b1, "sat");
        for (int i = 1; i <= 120; i++) begin
            send(1'b1, (i >= 4), $sformatf("sat_match_bit%0d", i));
        end
        check_eq("sat_bit_cnt", 32'(bus.bit_cnt), 32'd99);
        check_eq("sat_match_cnt", 32'(bus.match_cnt), 32'd99);

        // Clear together with a hitting bit and a new pattern
        do_reset(4'b1011, 1'b1, "clr");
        run_stream(32'b101101, 32'b000100, 6, "clr_pre");
        check_eq("clr_pre_match_cnt", 32'(bus.match_cnt), 32'd1);
        @(negedge clk);
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        bus.clear     = 1'b1;
        bus.pattern   = 4'b0101;
        @(posedge clk);
        #1;
        check_eq("clr_match", 32'(bus.match), 32'd0);
        check_eq("clr_match_cnt", 32'(bus.match_cnt), 32'd0);
        check_eq("clr_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        check_eq("clr_history", 32'(bus.history), 32'd0);
        check_eq("clr_fill", 32'(bus.fill_state), 32'(EMPTY));
        check_eq("clr_pat_q", 32'(bus.pat_q), 32'b0101);
        run_stream(32'b0101, 32'b0001, 4, "clr_post");
        check_eq("clr_post_bit_cnt", 32'(bus.bit_cnt), 32'd4);

        // Pattern change without clear is ignored
        do_reset(4'b1011, 1'b1, "patchg");
        send(1'b1, 1'b0, "patchg_b1");
        send(1'b0, 1'b0, "patchg_b2");
        bus.pattern = 4'b0000;
        send(1'b1, 1'b0, "patchg_b3");
        send(1'b1, 1'b1, "patchg_b4");
        check_eq("patchg_pat_q", 32'(bus.pat_q), 32'b1011);

        // Reset after three bits discards the partial window
        run_stream(32'b101, 32'b000, 3, "midrst_pre");
        do_reset(4'b1011, 1'b1, "midrst");
        run_stream(32'b1011, 32'b0001, 4, "midrst_post");
        check_eq("midrst_bit_cnt", 32'(bus.bit_cnt), 32'd4);
        check_eq("midrst_match_cnt", 32'(bus.match_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
